// File: rtl/vga_frame_capture.sv
// Receive-side VGA frame grabber: rebuilds one frame of pixels from sync/blank/rgb,
// writes it to a linear frame memory port, and checks line/frame timing.
module vga_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              h_sync,
    input  logic              v_sync,
    input  logic              blank_n,
    input  logic [DATA_W-1:0] rgb,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [9:0]        line_count,
    output logic              err_hlen,
    output logic              err_vlen,
    output logic              err_htotal,
    output logic [1:0]        fsm_state
);

    localparam int PIX_MAX = H_ACTIVE * V_ACTIVE - 1;
    localparam int RUN_W   = $clog2(H_ACTIVE + 2) + 1;
    localparam int HT_W    = $clog2(H_TOTAL + 2) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, FINISH} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              prev_hs, prev_vs, prev_bl;
    logic              hs_fall, vs_fall, vs_rise, bl_fall;
    logic              in_cap, line_end;
    logic [ADDR_W-1:0] pix_cnt;
    logic              pix_full;
    logic [RUN_W-1:0]  run, run_inc, end_len;
    logic [HT_W-1:0]   hcnt;
    logic              hs_seen;

    // Edges are taken against the previous pix_en-qualified sample only.
    assign hs_fall = pix_en & prev_hs & ~h_sync;
    assign vs_fall = pix_en & prev_vs & ~v_sync;
    assign vs_rise = pix_en & ~prev_vs & v_sync;
    assign bl_fall = pix_en & prev_bl & ~blank_n;

    assign in_cap    = (state == CAPTURE);
    assign fsm_state = state;

    assign run_inc = (run == {RUN_W{1'b1}}) ? run : run + 1'b1;
    // A v_sync cut while blank_n is still high ends the line including this sample.
    assign line_end = in_cap & (bl_fall | (vs_fall & blank_n));
    assign end_len  = bl_fall ? run : run_inc;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_VS;
                end
            end
            WAIT_VS: begin
                busy = 1'b1;
                if (vs_rise) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (vs_fall) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_hs    <= 1'b1;
            prev_vs    <= 1'b1;
            prev_bl    <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            line_count <= '0;
            err_hlen   <= 1'b0;
            err_vlen   <= 1'b0;
            err_htotal <= 1'b0;
            pix_cnt    <= '0;
            pix_full   <= 1'b0;
            run        <= '0;
            hcnt       <= '0;
            hs_seen    <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= 1'b0;

            if (pix_en) begin
                prev_hs <= h_sync;
                prev_vs <= v_sync;
                prev_bl <= blank_n;
                if (hs_fall)
                    hcnt <= HT_W'(1);
                else if (hcnt != {HT_W{1'b1}})
                    hcnt <= hcnt + 1'b1;
            end

            if (accept) begin
                line_count <= '0;
                err_hlen   <= 1'b0;
                err_vlen   <= 1'b0;
                err_htotal <= 1'b0;
                pix_cnt    <= '0;
                pix_full   <= 1'b0;
                run        <= '0;
                hs_seen    <= 1'b0;
            end else if (in_cap && pix_en) begin
                // Writes stop once the last frame address has been used.
                if (blank_n && !pix_full) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_cnt;
                    wr_data <= rgb;
                    if (pix_cnt == ADDR_W'(PIX_MAX))
                        pix_full <= 1'b1;
                    else
                        pix_cnt <= pix_cnt + 1'b1;
                end

                if (line_end) begin
                    if (line_count != 10'h3FF) line_count <= line_count + 1'b1;
                    if (end_len != RUN_W'(H_ACTIVE)) err_hlen <= 1'b1;
                    run <= '0;
                end else if (blank_n) begin
                    run <= run_inc;
                end else begin
                    run <= '0;
                end

                // The first falling edge in a capture only opens the first period.
                if (hs_fall) begin
                    hs_seen <= 1'b1;
                    if (hs_seen && hcnt != HT_W'(H_TOTAL)) err_htotal <= 1'b1;
                end
            end

            if (state == FINISH)
                err_vlen <= (line_count != 10'(V_ACTIVE));
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced video mode: generated frames with random
// pixel data, a pixel scoreboard, and frame-level expectations for each scenario.
module tb_vga_frame_capture;

    localparam int H_ACT  = 16;
    localparam int V_ACT  = 6;
    localparam int H_TOT  = 24;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int NPIX   = H_ACT * V_ACT;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pix_en = 1'b0;
    logic              h_sync = 1'b1;
    logic              v_sync = 1'b1;
    logic              blank_n = 1'b0;
    logic [DATA_W-1:0] rgb = '0;
    logic              start = 1'b0;
    logic              busy, done, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [9:0]        line_count;
    logic              err_hlen, err_vlen, err_htotal;
    logic [1:0]        fsm_state;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int pix_idx = 0;

    vga_frame_capture #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_TOTAL(H_TOT),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync),
        .v_sync(v_sync), .blank_n(blank_n), .rgb(rgb), .start(start),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .line_count(line_count), .err_hlen(err_hlen),
        .err_vlen(err_vlen), .err_htotal(err_htotal), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write must match the oldest expected pixel.
    always @(negedge clk) begin
        logic [ADDR_W+DATA_W-1:0] e;
        if (done) done_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                check("wr_data", wr_data, e[DATA_W-1:0]);
            end
        end
    end

    task automatic send_sample(input logic hs, input logic vs, input logic bl,
                               input logic [DATA_W-1:0] d, input logic st, input logic rs);
        h_sync = hs; v_sync = vs; blank_n = bl; rgb = d; start = st; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0; start = 1'b0;
        if (rs) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("rst_wr_en", wr_en, 0);
            check("rst_busy", busy, 0);
        end
        repeat ($urandom_range(1, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    // Frame layout: act active lines, 1 front-porch line, 2 v_sync lines, 1 back-porch line.
    // When cap is set, active pixels are expected as writes until rst_pix pixels are issued.
    task automatic drive_frame(input int act, input int short_ln, input int long_ln,
                               input int start_ln, input bit cap, input int rst_pix);
        bit cap_on = cap;
        for (int ln = 0; ln < act + 4; ln++) begin
            int line_len = (ln == long_ln) ? H_TOT + 1 : H_TOT;
            int act_len  = (ln < act) ? ((ln == short_ln) ? H_ACT - 1 : H_ACT) : 0;
            logic vs = !(ln == act + 1 || ln == act + 2);
            for (int s = 0; s < line_len; s++) begin
                logic bl = (s < act_len);
                logic hs = !(s >= H_ACT + 2 && s < H_ACT + 5);
                logic [DATA_W-1:0] d = DATA_W'($urandom_range(0, 255));
                logic do_rst = 1'b0;
                if (cap_on && bl) begin
                    if (pix_idx < NPIX) exp_q.push_back({ADDR_W'(pix_idx), d});
                    pix_idx++;
                    if (pix_idx == rst_pix) begin
                        do_rst = 1'b1;
                        cap_on = 1'b0;
                    end
                end
                send_sample(hs, vs, bl, d, (ln == start_ln && s == 0), do_rst);
            end
        end
    endtask

    task automatic verify(input string name, input int act, input int short_ln,
                          input int long_ln, input int d0, input int w0);
        bit short_ok = (short_ln >= 0 && short_ln < act);
        bit long_ok  = (long_ln >= 0 && long_ln < act);
        int npx      = act * H_ACT - (short_ok ? 1 : 0);
        if (npx > NPIX) npx = NPIX;
        check({name, "_done"}, done_cnt - d0, 1);
        check({name, "_writes"}, wr_cnt - w0, npx);
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_lines"}, line_count, act);
        check({name, "_err_hlen"}, err_hlen, short_ok);
        check({name, "_err_vlen"}, err_vlen, act != V_ACT);
        check({name, "_err_htotal"}, err_htotal, long_ok);
        check({name, "_busy"}, busy, 0);
    endtask

    // Start during frame A (at start_ln), capture frame B; a stray start in B must be ignored.
    task automatic run_test(input string name, input int start_ln, input int act,
                            input int short_ln, input int long_ln);
        int d0 = done_cnt;
        int w0 = wr_cnt;
        pix_idx = 0;
        drive_frame(V_ACT, -1, -1, start_ln, 1'b0, -1);
        check({name, "_armed"}, busy, 1);
        drive_frame(act, short_ln, long_ln, 1, 1'b1, -1);
        verify(name, act, short_ln, long_ln, d0, w0);
    endtask

    initial begin
        int d0, w0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_wr_en0", wr_en, 0);
        check("rst_wr_addr0", wr_addr, 0);
        check("rst_wr_data0", wr_data, 0);
        check("rst_lines0", line_count, 0);
        check("rst_errs0", {err_hlen, err_vlen, err_htotal}, 0);

        run_test("ideal", V_ACT, V_ACT, -1, -1);
        run_test("short", V_ACT, V_ACT, 2, -1);
        run_test("midstart", 2, V_ACT, -1, -1);
        run_test("extra_line", V_ACT, V_ACT + 1, -1, -1);
        run_test("long_h", V_ACT, V_ACT, -1, 3);

        // Reset in the middle of a capture, then a clean capture of a later frame.
        d0 = done_cnt;
        w0 = wr_cnt;
        pix_idx = 0;
        drive_frame(V_ACT, -1, -1, V_ACT, 1'b0, -1);
        drive_frame(V_ACT, 1, -1, V_ACT, 1'b1, 40);
        check("rst_mid_done", done_cnt - d0, 0);
        check("rst_mid_writes", wr_cnt - w0, 40);
        check("rst_mid_left", exp_q.size(), 0);
        d0 = done_cnt;
        w0 = wr_cnt;
        pix_idx = 0;
        drive_frame(V_ACT, -1, -1, -1, 1'b1, -1);
        verify("after_rst", V_ACT, -1, -1, d0, w0);

        for (int k = 0; k < 3; k++) begin
            int act = V_ACT + int'($urandom_range(0, 1));
            int sl  = int'($urandom_range(0, V_ACT + 2)) - 1;
            int ll  = int'($urandom_range(0, V_ACT + 2)) - 1;
            run_test("random", V_ACT, act, sl, ll);
        end

        repeat (4) @(posedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
